// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the asynchronous FIFO read-side drain block.
package fifo_rd_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;
  localparam int unsigned SKID_DEPTH     = 2;
  localparam int unsigned OCC_W          = 2;
  localparam int unsigned CNT_W          = 16;

  typedef logic [OCC_W-1:0] occ_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

  // Occupancy after this cycle's capture/pop; the operands never exceed 2 in total.
  function automatic occ_t occ_after(input occ_t cnt, input logic add, input logic sub);
    return occ_t'(cnt + occ_t'(add) - occ_t'(sub));
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry register skid buffer: captures FIFO read data at the tail, presents the oldest byte at the head.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned DEPTH  = SKID_DEPTH
) (
  input  logic              rd_clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output occ_t              stored
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              head_ptr;
  logic              tail_ptr;
  occ_t              cnt_q;

  // Storage, pointers and occupancy; reset flushes contents so the head reads zero.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[tail_ptr] <= wr_data;
        tail_ptr      <= ~tail_ptr;
      end
      if (pop) begin
        head_ptr <= ~head_ptr;
      end
      cnt_q <= occ_after(cnt_q, wr_en, pop);
    end
  end

  // Guard against popping an empty buffer or writing into a full one.
  always_ff @(posedge rd_clk) begin
    if (!rst) begin
      assert (!(pop && (cnt_q == '0)));
      assert ((3'(cnt_q) + 3'(wr_en)) <= 3'(DEPTH));
    end
  end

  assign head_data = mem[head_ptr];
  assign stored    = cnt_q;

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side drain controller: issues rd_enb to the FIFO, absorbs its one-cycle read
// latency in a 2-entry skid buffer and streams bytes out on m_valid/m_ready.
// Optional transfer counter output rd_cnt when FIFO_RD_DRAIN_CNT_EN is defined.
module fifo_rd_drain #(
  parameter int unsigned DATA_W     = fifo_rd_pkg::DATA_W_DEFAULT,
  parameter int unsigned SKID_DEPTH = fifo_rd_pkg::SKID_DEPTH
) (
  input  logic              rd_clk,
  input  logic              rst,
  input  logic              empty,
  input  logic [DATA_W-1:0] data_out,
  output logic              rd_enb,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
`ifdef FIFO_RD_DRAIN_CNT_EN
  ,
  output logic [15:0]       rd_cnt
`endif
);

  import fifo_rd_pkg::*;

  occ_t stored;
  logic inflight;
  logic pop_c;
  occ_t occ_next_c;

  // Transfer handshake and read issue; reads stop once buffered plus in-flight bytes reach the skid depth.
  always_comb begin
    pop_c      = 1'b0;
    occ_next_c = '0;
    rd_enb     = 1'b0;
    pop_c      = m_valid && m_ready;
    occ_next_c = occ_after(stored, inflight, pop_c);
    rd_enb     = !rst && !empty && (occ_next_c < occ_t'(SKID_DEPTH));
  end

  // A read issued this cycle returns data next cycle; reset discards it.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= rd_enb;
    end
  end

  // Buffered plus in-flight bytes must never exceed the skid depth.
  always_ff @(posedge rd_clk) begin
    if (!rst) begin
      assert ((3'(stored) + 3'(inflight)) <= 3'(SKID_DEPTH));
    end
  end

  fifo_rd_skid #(
    .DATA_W (DATA_W),
    .DEPTH  (SKID_DEPTH)
  ) u_skid (
    .rd_clk    (rd_clk),
    .rst       (rst),
    .wr_en     (inflight),
    .wr_data   (data_out),
    .pop       (pop_c),
    .head_data (m_data),
    .stored    (stored)
  );

  assign m_valid = (stored != '0);

`ifdef FIFO_RD_DRAIN_CNT_EN
  cnt_t cnt_q;

  // Saturating count of completed downstream transfers.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (pop_c && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + cnt_t'(1);
    end
  end

  assign rd_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Self-checking bench for fifo_rd_drain: FIFO model, scoreboard queue and negedge monitor.
module tb_fifo_rd_drain;

  logic       rd_clk = 1'b0;
  logic       rst;
  logic       empty;
  logic [7:0] data_out;
  logic       rd_enb;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
`ifdef FIFO_RD_DRAIN_CNT_EN
  logic [15:0] rd_cnt;
`endif

  fifo_rd_drain #(
    .DATA_W     (8),
    .SKID_DEPTH (2)
  ) dut (
    .rd_clk   (rd_clk),
    .rst      (rst),
    .empty    (empty),
    .data_out (data_out),
    .rd_enb   (rd_enb),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready)
`ifdef FIFO_RD_DRAIN_CNT_EN
    ,
    .rd_cnt   (rd_cnt)
`endif
  );

  always #5 rd_clk = ~rd_clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         tb_cnt   = 0;
  logic [7:0] fifo_q [$];
  logic [7:0] exp_q  [$];
  int         rd_log [$];
  int         pop_log[$];
  logic       force_empty = 1'b0;
  logic       rd_seen     = 1'b0;
  logic [7:0] rd_pending  = 8'h00;
  logic       prev_hold   = 1'b0;
  logic [7:0] prev_data   = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // FIFO read port model: data appears one cycle after the read, empty follows the contents.
  always @(posedge rd_clk) begin
    cyc++;
    #1;
    if (rd_seen) data_out = rd_pending;
    #1;
    empty = force_empty || (fifo_q.size() == 0);
  end

  // Monitor: ordering scoreboard, stability under backpressure, empty-read guard, FIFO pops.
  always @(negedge rd_clk) begin
    rd_seen = 1'b0;
    if (rst) begin
      prev_hold = 1'b0;
      tb_cnt    = 0;
    end else begin
      if (empty) chk("rd_enb_while_empty", 32'(rd_enb), 32'd0);
      if (prev_hold) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
        pop_log.push_back(cyc);
        if (tb_cnt < 65535) tb_cnt++;
        if (exp_q.size() == 0) chk("spurious_byte", 32'(m_valid), 32'd0);
        else chk("data_order", 32'(m_data), 32'(exp_q.pop_front()));
      end else if (m_valid && (exp_q.size() == 0)) begin
        chk("spurious_valid", 32'(m_valid), 32'd0);
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      if (rd_enb) begin
        rd_log.push_back(cyc);
        if (!empty && (fifo_q.size() > 0)) begin
          rd_pending = fifo_q.pop_front();
          rd_seen    = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    m_ready     = 1'b1;
    force_empty = 1'b0;
    while (((exp_q.size() != 0) || m_valid) && (n < budget)) begin
      tick();
      n++;
    end
    chk({name, "_remaining"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic mid_reset();
    rst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    tick();
    rst = 1'b0;
    @(negedge rd_clk);
    chk("flush_m_valid", 32'(m_valid), 32'd0);
    chk("flush_m_data", 32'(m_data), 32'd0);
    repeat (6) tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst      = 1'b1;
    m_ready  = 1'b0;
    empty    = 1'b0;
    data_out = 8'h00;
    fifo_q.push_back(8'hEE);

    // Reset held with a non-empty FIFO.
    repeat (3) begin
      @(posedge rd_clk);
      @(negedge rd_clk);
      chk("reset_rd_enb", 32'(rd_enb), 32'd0);
      chk("reset_m_valid", 32'(m_valid), 32'd0);
      chk("reset_m_data", 32'(m_data), 32'd0);
    end
    tick();
    rst = 1'b0;
    fifo_q.delete();
    repeat (3) tick();

    // Streaming three bytes.
    rd_log.delete();
    pop_log.delete();
    m_ready = 1'b1;
    c0 = cyc;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    repeat (8) tick();
    chk("stream_rd_count", 32'(rd_log.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < rd_log.size()) chk("stream_rd_cycle", 32'(rd_log[i]), 32'(c0 + i));
      if (i < pop_log.size()) chk("stream_pop_cycle", 32'(pop_log[i]), 32'(c0 + 2 + i));
    end
    chk("stream_remaining", 32'(exp_q.size()), 32'd0);

    // Sustained throughput.
    pop_log.delete();
    for (int i = 0; i < 20; i++) push(8'($urandom));
    repeat (25) tick();
    chk("thru_count", 32'(pop_log.size()), 32'd20);
    if (pop_log.size() == 20) chk("thru_span", 32'(pop_log[19] - pop_log[0]), 32'd19);

    // Backpressure.
    m_ready = 1'b0;
    rd_log.delete();
    pop_log.delete();
    for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
    repeat (8) tick();
    chk("bp_rd_count", 32'(rd_log.size()), 32'd2);
    chk("bp_m_valid", 32'(m_valid), 32'd1);
    chk("bp_m_data", 32'(m_data), 32'h40);
    drain("bp", 40);
    chk("bp_delivered", 32'(pop_log.size()), 32'd5);

    // Empty rises right after a read: in-flight byte still delivered.
    rd_log.delete();
    m_ready = 1'b1;
    push(8'hA5);
    push(8'h3C);
    push(8'hC3);
    tick();
    force_empty = 1'b1;
    repeat (6) tick();
    chk("empty_rd_count", 32'(rd_log.size()), 32'd1);
    chk("empty_left", 32'(exp_q.size()), 32'd2);
    chk("empty_idle_valid", 32'(m_valid), 32'd0);
    drain("empty_edge", 40);

    // Reset while streaming (one stored, one in flight).
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(8'h60 + i));
    repeat (4) tick();
    mid_reset();
    push(8'h77);
    push(8'h88);
    drain("post_reset1", 40);

    // Reset with the buffer full under backpressure.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h90 + i));
    repeat (5) tick();
    mid_reset();
    push(8'h5A);
    drain("post_reset2", 40);

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      if ((fifo_q.size() < 16) && ($urandom_range(0, 2) == 0)) begin
        int k = int'($urandom_range(1, 3));
        for (int j = 0; j < k; j++) push(8'($urandom));
      end
      m_ready     = ($urandom_range(0, 3) != 0);
      force_empty = ($urandom_range(0, 11) == 0);
      tick();
    end
    drain("random", 200);

`ifdef FIFO_RD_DRAIN_CNT_EN
    rst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    chk("cnt_reset", 32'(rd_cnt), 32'd0);
    for (int i = 0; i < 300; i++) push(8'(i));
    drain("cnt300", 400);
    chk("rd_cnt_300", 32'(rd_cnt), 32'd300);
    chk("rd_cnt_model", 32'(rd_cnt), 32'(tb_cnt));
    for (int i = 0; i < 70000; i++) push(8'(i));
    drain("cnt_sat", 71000);
    chk("rd_cnt_sat", 32'(rd_cnt), 32'd65535);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
